// File: rtl/redmule_z_collector_pkg.sv
// Shared constants for the RedMulE Z collector: FP format encoding (matches the
// fpnew ordering) and the stall margin the engine controller relies on.
package redmule_z_collector_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  // Slots kept free per row for the element already in flight when the
  // controller drops the shared register enable.
  localparam int unsigned ZCollectorMargin = 1;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP8:     return 8;
      default: return 16;
    endcase
  endfunction

endpackage

// File: rtl/redmule_z_collector_if.sv
// Aligned Z vector stream from the collector towards the streamer.
interface redmule_z_collector_if
  import redmule_z_collector_pkg::*;
#(
  parameter int unsigned Width = 4,
  parameter int unsigned BITW  = fp_width(FP16)
);
  logic [Width-1:0][BITW-1:0] z;
  logic                       valid;
  logic                       ready;

  modport master (output z, output valid, input ready);
  modport slave  (input z, input valid, output ready);
endinterface

// File: rtl/redmule_z_fifo.sv
// Per-row Z FIFO; pop-before-push so a full FIFO still accepts a push on a pop.
module redmule_z_fifo #(
  parameter int unsigned BITW  = 16,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [BITW-1:0] wdata,
  output logic [BITW-1:0] rdata,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);
  logic [Depth-1:0][BITW-1:0] mem;
  logic [PtrW-1:0]            wptr, rptr;
  logic                       push_ok;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign push_ok = push & (~full | pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= wdata;
        wptr      <= nxt(wptr);
      end
      if (pop) rptr <= nxt(rptr);
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/redmule_z_collector.sv
// Captures staggered row outputs into per-row FIFOs and releases them as one
// aligned Z vector; raises stall before any row can overflow.
module redmule_z_collector
  import redmule_z_collector_pkg::*;
#(
  parameter fp_format_e  FpFormat = FP16,
  parameter int unsigned Width    = 4,
  parameter int unsigned Depth    = 4,
  localparam int unsigned BITW    = fp_width(FpFormat),
  localparam int unsigned CntW    = $clog2(Depth + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [Width-1:0][BITW-1:0] z_i,
  input  logic [Width-1:0]           z_valid_i,
  input  logic                       flush_i,
  redmule_z_collector_if.master      zs,
  output logic                       stall_o,
  output logic [Width-1:0][CntW-1:0] count_o,
  output logic                       overflow_o
);
  logic [Width-1:0][BITW-1:0] rdata, z_masked;
  logic [Width-1:0]           full, empty;
  logic                       z_valid, pop;

  assign z_valid  = ~|empty;
  assign pop      = z_valid & zs.ready;
  assign zs.valid = z_valid;
  assign zs.z     = z_masked;

  for (genvar r = 0; r < Width; r++) begin : g_row
    redmule_z_fifo #(.BITW(BITW), .Depth(Depth)) i_fifo (
      .clk_i, .rst_ni,
      .flush (flush_i),
      .push  (z_valid_i[r]),
      .pop   (pop),
      .wdata (z_i[r]),
      .rdata (rdata[r]),
      .count (count_o[r]),
      .full  (full[r]),
      .empty (empty[r])
    );
  end

  // Stale storage must never leak out once a row is empty (e.g. after flush).
  always_comb begin
    z_masked = '0;
    stall_o  = 1'b0;
    for (int r = 0; r < Width; r++) begin
      if (!empty[r]) z_masked[r] = rdata[r];
      if (count_o[r] >= CntW'(Depth - ZCollectorMargin)) stall_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                           overflow_o <= 1'b0;
    else if (flush_i)                      overflow_o <= 1'b0;
    else if (|(z_valid_i & full) && !pop)  overflow_o <= 1'b1;
  end
endmodule

// File: tb/tb_redmule_z_collector.sv
// Bench for redmule_z_collector: directed table, async reset and random traffic
// against a queue-based model.
module tb_redmule_z_collector;
  import redmule_z_collector_pkg::*;
  localparam int W = 4;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic [W-1:0][15:0]   z_i;
  logic [W-1:0]         z_valid_i;
  logic                 flush_i;
  logic                 stall_o;
  logic [W-1:0][2:0]    count_o;
  logic                 overflow_o;

  redmule_z_collector_if #(.Width(W), .BITW(16)) zs ();

  redmule_z_collector #(.FpFormat(FP16), .Width(W), .Depth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .z_i(z_i), .z_valid_i(z_valid_i),
    .flush_i(flush_i), .zs(zs), .stall_o(stall_o), .count_o(count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per row plus the sticky overflow flag.
  logic [15:0] q[W][$];
  bit          m_ovf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < W; r++) q[r].delete();
    m_ovf = 0;
  endtask

  task automatic model_edge();
    bit hs;
    if (flush_i) model_clear();
    else begin
      hs = zs.ready;
      for (int r = 0; r < W; r++) if (q[r].size() == 0) hs = 0;
      for (int r = 0; r < W; r++) begin
        if (hs) void'(q[r].pop_front());
        if (z_valid_i[r]) begin
          if (q[r].size() < DEPTH) q[r].push_back(z_i[r]);
          else m_ovf = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic mv, ms;
    logic [W-1:0][15:0] mz;
    logic [W-1:0][2:0]  mc;
    mv = 1; ms = 0; mz = '0; mc = '0;
    for (int r = 0; r < W; r++) begin
      mc[r] = 3'(q[r].size());
      if (q[r].size() != 0) mz[r] = q[r][0];
      else mv = 0;
      if (q[r].size() >= DEPTH - 1) ms = 1;
    end
    chk({tag, ".valid"}, zs.valid, mv);
    chk({tag, ".z"},     zs.z,     mz);
    chk({tag, ".count"}, count_o,  mc);
    chk({tag, ".stall"}, stall_o,  ms);
    chk({tag, ".ovf"},   overflow_o, m_ovf);
  endtask

  // Drive one cycle's inputs, clock it, update the model, land 1 ns past the edge.
  task automatic step(input logic [W-1:0] v, input logic [15:0] base,
                      input logic rdy, input logic fl);
    z_valid_i = v;
    for (int r = 0; r < W; r++) z_i[r] = base + 16'(r);
    zs.ready = rdy;
    flush_i  = fl;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic [W-1:0]       v;
    logic [15:0]        base;
    logic               rdy, fl;
    logic               ev, es, eo;
    logic [W-1:0][2:0]  ec;
    logic [W-1:0][15:0] ez;
  } vec_t;

  function automatic vec_t mk(input logic [W-1:0] v, input logic [15:0] base,
                              input logic rdy, input logic fl, input logic ev,
                              input logic es, input logic eo,
                              input logic [W-1:0][2:0] ec, input logic [W-1:0][15:0] ez);
    vec_t t;
    t.v = v; t.base = base; t.rdy = rdy; t.fl = fl;
    t.ev = ev; t.es = es; t.eo = eo; t.ec = ec; t.ez = ez;
    return t;
  endfunction

  function automatic logic [W-1:0][2:0] c4(input int a3, input int a2, input int a1, input int a0);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  function automatic logic [W-1:0][15:0] mkz(input logic [15:0] base, input logic [W-1:0] m);
    logic [W-1:0][15:0] z;
    z = '0;
    for (int r = 0; r < W; r++) if (m[r]) z[r] = base + 16'(r);
    return z;
  endfunction

  vec_t tbl[22];

  initial begin
    logic [W-1:0][15:0] z19;
    z19 = mkz(16'h1200, 4'b1010) | mkz(16'h1300, 4'b0100);
    // staggered rows
    tbl[0]  = mk(4'b0001, 16'h3C00, 1, 0, 0, 0, 0, c4(0,0,0,1), mkz(16'h3C00, 4'b0001));
    tbl[1]  = mk(4'b0010, 16'h3C00, 1, 0, 0, 0, 0, c4(0,0,1,1), mkz(16'h3C00, 4'b0011));
    tbl[2]  = mk(4'b0100, 16'h3C00, 1, 0, 0, 0, 0, c4(0,1,1,1), mkz(16'h3C00, 4'b0111));
    tbl[3]  = mk(4'b1000, 16'h3C00, 1, 0, 1, 0, 0, c4(1,1,1,1), mkz(16'h3C00, 4'b1111));
    tbl[4]  = mk(4'b0000, 16'h3C00, 1, 0, 0, 0, 0, c4(0,0,0,0), '0);
    // backpressure into overflow
    tbl[5]  = mk(4'b1111, 16'h0500, 0, 0, 1, 0, 0, c4(1,1,1,1), mkz(16'h0500, 4'b1111));
    tbl[6]  = mk(4'b1111, 16'h0600, 0, 0, 1, 0, 0, c4(2,2,2,2), mkz(16'h0500, 4'b1111));
    tbl[7]  = mk(4'b1111, 16'h0700, 0, 0, 1, 1, 0, c4(3,3,3,3), mkz(16'h0500, 4'b1111));
    tbl[8]  = mk(4'b1111, 16'h0800, 0, 0, 1, 1, 0, c4(4,4,4,4), mkz(16'h0500, 4'b1111));
    tbl[9]  = mk(4'b1111, 16'h0900, 0, 0, 1, 1, 1, c4(4,4,4,4), mkz(16'h0500, 4'b1111));
    tbl[10] = mk(4'b0000, 16'h0000, 0, 1, 0, 0, 0, c4(0,0,0,0), '0);
    // full with simultaneous push and pop
    tbl[11] = mk(4'b1111, 16'h0B00, 0, 0, 1, 0, 0, c4(1,1,1,1), mkz(16'h0B00, 4'b1111));
    tbl[12] = mk(4'b1111, 16'h0C00, 0, 0, 1, 0, 0, c4(2,2,2,2), mkz(16'h0B00, 4'b1111));
    tbl[13] = mk(4'b1111, 16'h0D00, 0, 0, 1, 1, 0, c4(3,3,3,3), mkz(16'h0B00, 4'b1111));
    tbl[14] = mk(4'b1111, 16'h0E00, 0, 0, 1, 1, 0, c4(4,4,4,4), mkz(16'h0B00, 4'b1111));
    tbl[15] = mk(4'b1111, 16'h0F00, 1, 0, 1, 1, 0, c4(4,4,4,4), mkz(16'h0C00, 4'b1111));
    tbl[16] = mk(4'b0000, 16'h0000, 1, 0, 1, 1, 0, c4(3,3,3,3), mkz(16'h0D00, 4'b1111));
    tbl[17] = mk(4'b0000, 16'h0000, 0, 1, 0, 0, 0, c4(0,0,0,0), '0);
    // uneven fill then flush together with a push
    tbl[18] = mk(4'b1010, 16'h1200, 0, 0, 0, 0, 0, c4(1,0,1,0), mkz(16'h1200, 4'b1010));
    tbl[19] = mk(4'b1110, 16'h1300, 0, 0, 0, 0, 0, c4(2,1,2,0), z19);
    tbl[20] = mk(4'b0010, 16'h1400, 0, 0, 0, 1, 0, c4(2,1,3,0), z19);
    tbl[21] = mk(4'b1111, 16'h1500, 1, 1, 0, 0, 0, c4(0,0,0,0), '0);

    rst_ni = 1'b0; z_i = '0; z_valid_i = '0; flush_i = 1'b0; zs.ready = 1'b0;
    model_clear();
    #12 rst_ni = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step('0, 16'h0, 0, 0);
      check_all($sformatf("idle%0d", i));
    end

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].v, tbl[i].base, tbl[i].rdy, tbl[i].fl);
      chk($sformatf("tbl%0d.valid", i), zs.valid,   tbl[i].ev);
      chk($sformatf("tbl%0d.stall", i), stall_o,    tbl[i].es);
      chk($sformatf("tbl%0d.ovf", i),   overflow_o, tbl[i].eo);
      chk($sformatf("tbl%0d.count", i), count_o,    tbl[i].ec);
      chk($sformatf("tbl%0d.z", i),     zs.z,       tbl[i].ez);
      check_all($sformatf("tbl%0d.m", i));
    end

    // async reset in the middle of a cycle with data held in the FIFOs
    step(4'b1111, 16'h2000, 0, 0);
    step(4'b0111, 16'h2100, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    model_clear();
    chk("arst.valid", zs.valid, 1'b0);
    chk("arst.z", zs.z, 64'h0);
    chk("arst.count", count_o, 12'h0);
    chk("arst.stall", stall_o, 1'b0);
    chk("arst.ovf", overflow_o, 1'b0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    step(4'b1111, 16'h2200, 0, 0);
    chk("arst.next.z", zs.z, mkz(16'h2200, 4'b1111));
    chk("arst.next.valid", zs.valid, 1'b1);
    check_all("arst.next");
    step('0, 16'h0, 1, 0);
    check_all("arst.pop");

    // random traffic, with phases of held-off consumer to reach stall/overflow
    for (int i = 0; i < 600; i++) begin
      logic rdy;
      rdy = ((i % 80) < 25) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      step(4'($urandom), 16'($urandom), rdy, 1'($urandom_range(0, 59) == 0));
      check_all($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/redmule_z_collector.md
# redmule_z_collector

Output-side collector for the RedMulE datapath. Each row produces one accumulated Z element at its tail register with no backpressure of its own, and the rows finish staggered in time. This block captures those elements into per-row FIFOs and re-aligns them into one packed Z vector. It presents that vector on a valid/ready stream towards the streamer, and asserts a stall that the engine controller uses to drop the rows' shared register enable.

## Interface
Parameters:
- FpFormat, fpnew_pkg::FP16: element format; BITW = fpnew_pkg::fp_width(FpFormat) (localparam)
- Width, 4: number of rows feeding the collector (W)
- Depth, 4: entries per row FIFO; legal values ≥ 2
- CntW, $clog2(Depth+1): localparam, occupancy counter width

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- z_i  in  [W-1:0][BITW-1:0]  row tail outputs
- z_valid_i  in  [W-1:0]  per-row capture strobe; one element per asserted bit per cycle
- flush_i  in  1  synchronous clear of all FIFOs and error flag
- z_o  out  [W-1:0][BITW-1:0]  aligned vector, head of each FIFO
- z_valid_o  out  1  all W FIFOs non-empty
- z_ready_i  in  1  consumer accepts z_o
- stall_o  out  1  backpressure to engine controller
- count_o  out  [W-1:0][CntW-1:0]  per-row occupancy
- overflow_o  out  1  sticky: push attempted into full FIFO

## Operation
- Reset (async, rst_ni low): all occupancies 0, read/write pointers 0, storage cleared to '0, overflow_o 0. Resulting outputs: z_o '0, z_valid_o 0, stall_o 0, count_o all 0.
- Push, per row r:
  - When z_valid_i[r] is high and FIFO r is not full, z_i[r] is written at wptr[r].
  - wptr[r] wraps modulo Depth.
- Pop:
  - The handshake is z_valid_o & z_ready_i.
  - On handshake, all W FIFOs pop together; each rptr wraps modulo Depth.
  - Rows never pop individually.
- z_valid_o = AND over r of (count[r] != 0).
- z_o[r] = storage[r][rptr[r]], combinational from registered state.
- stall_o = OR over r of (count[r] >= Depth-1).
  - This leaves one slot of margin per row, absorbing the element already in flight when the controller deasserts the register enable.
- Occupancy update per row:
  - count' = count + push - pop.
  - Push and pop in the same cycle leave count unchanged.
- Full FIFO with push:
  - If a pop handshake occurs in the same cycle, the push is accepted: pop-before-push semantics, and count stays Depth.
  - Otherwise the element is dropped, storage is unchanged, and overflow_o is set sticky.
- Empty FIFO with push: the element becomes visible on z_o the next cycle. There is no same-cycle bypass.
- z_ready_i without z_valid_o: no effect.
- flush_i:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: all counts 0, pointers 0, overflow_o 0.
  - Storage contents are don't-care after flush, but z_o must read '0 when its FIFO is empty. The implementation masks z_o[r] with count[r] != 0.
- Stream rule: once z_valid_o is high it stays high with z_o stable until the handshake or a flush. This holds automatically, because only a pop or a flush can empty a FIFO.

## Timing
- Latency:
  - A push at edge t is visible on count_o after edge t.
  - The last missing row pushed at edge t raises z_valid_o in cycle t+1.
- Handshake at edge t: next head or deassertion is visible in cycle t+1.
- stall_o is combinational from registered counts, so it is registered-quality with no input-to-output paths.
- No combinational path from z_ready_i or z_valid_i to any output.
- Throughput: one vector per cycle while all rows push every cycle and z_ready_i is held high.

## Structure
- Sub-module redmule_z_fifo (one per row, generate loop):
  - Parameters: BITW, Depth.
  - Ports: push, pop, flush, data in/out, count, full, empty.
  - The top holds only the valid AND, the stall OR, the overflow flag and z_o masking.
- No new package types. BITW is derived via fpnew_pkg::fp_width.
- If the engine controller needs the stall margin, a shared constant ZCollectorMargin = 1 goes into redmule_pkg.

## Test plan
- Reset then idle: z_o = '0, z_valid_o = 0, stall_o = 0, count_o all 0 for 10 cycles.
- Staggered rows, W=4:
  - Stimulus: row r pushes 16'h3C00+r at cycle r, with z_ready_i=1.
  - Required: z_valid_o rises in cycle 4 with z_o = {16'h3C03,16'h3C02,16'h3C01,16'h3C00}, then falls in cycle 5.
- Backpressure, Depth=4:
  - Stimulus: all rows push every cycle with z_ready_i=0.
  - Required: stall_o rises the cycle after the 3rd push; the 4th push fills; a 5th push sets overflow_o and leaves count=4.
- Full with simultaneous push+pop: all counts 4, push and z_ready_i=1 in the same cycle → counts stay 4, overflow_o stays 0, FIFO order preserved.
- Flush mid-stream: counts {2,1,3,0}; flush_i asserted together with a push → next cycle all counts 0, z_valid_o 0, overflow_o 0, z_o '0.
- Async reset mid-operation: rst_ni low with data held → outputs immediately reset values; after release, first new vector reads correctly.
